// File: rtl/alu_exec_unit_pkg.sv
// Shared types and encodings for the integer execute stage: instruction and
// writeback packets, opcode and funct3 constants.
package alu_exec_unit_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // uop_0 carries funct3 for the result path, uop_1 the branch compare
  typedef struct packed {
    logic              is_valid;
    logic [6:0]        opcode;
    logic [2:0]        uop_0;
    logic [2:0]        uop_1;
    logic              funct7_5;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] src_0_a;
    logic [DATA_W-1:0] src_0_b;
    logic [DATA_W-1:0] src_1_a;
    logic [DATA_W-1:0] src_1_b;
    logic              has_rd;
    logic [TAG_W-1:0]  dest_tag;
    logic              br_taken;
  } instruction_t;

  typedef struct packed {
    logic              is_valid;
    logic [TAG_W-1:0]  dest_tag;
    logic [DATA_W-1:0] result;
  } writeback_packet_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue, writeback and branch-resolution signals between the ALU execute
// stage (slave) and its reservation station / CDB / front end (master).
interface alu_exec_unit_if;
  import alu_exec_unit_pkg::*;

  logic              flush;
  logic              rs_read_rdy;
  instruction_t      execute_pkt;
  logic              alu_re;
  writeback_packet_t wb_pkt;
  logic              cdb_gnt;
  logic              br_valid;
  logic              br_taken_act;
  logic              br_mispredict;
  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] br_pc;

  modport master (
    output flush, rs_read_rdy, execute_pkt, cdb_gnt,
    input  alu_re, wb_pkt, br_valid, br_taken_act, br_mispredict, br_target, br_pc
  );

  modport slave (
    input  flush, rs_read_rdy, execute_pkt, cdb_gnt,
    output alu_re, wb_pkt, br_valid, br_taken_act, br_mispredict, br_target, br_pc
  );

endinterface

// File: rtl/alu_exec_unit_alu_core.sv
// Combinational ALU result and branch/jump resolution for one instruction;
// zero latency, no flow control.
module alu_core
  import alu_exec_unit_pkg::*;
(
  input  instruction_t      pkt,
  output logic [DATA_W-1:0] result,
  output logic              wb_en,
  output logic              br_en,
  output logic              br_taken_act,
  output logic              br_mispredict,
  output logic [DATA_W-1:0] br_target
);

  logic [DATA_W-1:0] add_sum;
  logic [DATA_W-1:0] pc_plus4;
  logic [4:0]        shamt;
  logic              alt;
  logic              unused_fields;

  assign add_sum  = pkt.src_0_a + pkt.src_0_b;
  assign pc_plus4 = pkt.pc + DATA_W'(4);
  assign shamt    = pkt.src_0_b[4:0];
  // OP-IMM only honours funct7[5] for SRAI; ADDI immediates may have it set
  assign alt      = (pkt.opcode == OP) ? pkt.funct7_5
                                       : (pkt.funct7_5 && (pkt.uop_0 == F3_SR));
  assign unused_fields = &{1'b0, pkt.is_valid, pkt.has_rd, pkt.dest_tag};

  always_comb begin
    result       = '0;
    wb_en        = 1'b0;
    br_en        = 1'b0;
    br_taken_act = 1'b0;
    br_target    = '0;
    case (pkt.opcode)
      OP, OP_IMM: begin
        wb_en = 1'b1;
        case (pkt.uop_0)
          F3_ADD:  result = alt ? (pkt.src_0_a - pkt.src_0_b) : add_sum;
          F3_SLL:  result = pkt.src_0_a << shamt;
          F3_SLT:  result = DATA_W'($signed(pkt.src_0_a) < $signed(pkt.src_0_b));
          F3_SLTU: result = DATA_W'(pkt.src_0_a < pkt.src_0_b);
          F3_XOR:  result = pkt.src_0_a ^ pkt.src_0_b;
          F3_SR:   result = alt ? $unsigned($signed(pkt.src_0_a) >>> shamt)
                                : (pkt.src_0_a >> shamt);
          F3_OR:   result = pkt.src_0_a | pkt.src_0_b;
          default: result = pkt.src_0_a & pkt.src_0_b;
        endcase
      end
      LUI: begin
        wb_en  = 1'b1;
        result = pkt.src_0_b;
      end
      AUIPC: begin
        wb_en  = 1'b1;
        result = add_sum;
      end
      JAL, JALR: begin
        wb_en        = 1'b1;
        result       = pc_plus4;
        br_en        = 1'b1;
        br_taken_act = 1'b1;
        br_target    = (pkt.opcode == JALR) ? {add_sum[DATA_W-1:1], 1'b0} : add_sum;
      end
      BRANCH: begin
        br_en = 1'b1;
        case (pkt.uop_1)
          F3_BEQ:  br_taken_act = (pkt.src_1_a == pkt.src_1_b);
          F3_BNE:  br_taken_act = (pkt.src_1_a != pkt.src_1_b);
          F3_BLT:  br_taken_act = ($signed(pkt.src_1_a) <  $signed(pkt.src_1_b));
          F3_BGE:  br_taken_act = ($signed(pkt.src_1_a) >= $signed(pkt.src_1_b));
          F3_BLTU: br_taken_act = (pkt.src_1_a <  pkt.src_1_b);
          F3_BGEU: br_taken_act = (pkt.src_1_a >= pkt.src_1_b);
          default: br_taken_act = 1'b0;
        endcase
        br_target = br_taken_act ? add_sum : pc_plus4;
      end
      default: ;
    endcase
  end

  assign br_mispredict = br_en && (br_taken_act != pkt.br_taken);

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: one-cycle accept-to-writeback/branch latency; alu_re drops
// while the writeback FIFO is full, independent of cdb_gnt.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int OUTQ_DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  alu_exec_unit_if.slave  bus
);

  localparam int PTR_W = $clog2(OUTQ_DEPTH);
  localparam int CNT_W = $clog2(OUTQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUTQ_DEPTH);

  writeback_packet_t fifo_q [OUTQ_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              kill;
  logic              accept;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] core_result;
  logic              core_wb_en;
  logic              core_br_en;
  logic              core_taken;
  logic              core_mispredict;
  logic [DATA_W-1:0] core_target;

  logic              br_valid_q;
  logic              br_taken_q;
  logic              br_mispredict_q;
  logic [XLEN-1:0]   br_target_q;
  logic [XLEN-1:0]   br_pc_q;

  alu_core u_alu_core (
    .pkt           (bus.execute_pkt),
    .result        (core_result),
    .wb_en         (core_wb_en),
    .br_en         (core_br_en),
    .br_taken_act  (core_taken),
    .br_mispredict (core_mispredict),
    .br_target     (core_target)
  );

  assign kill       = rst || bus.flush;
  assign bus.alu_re = !rst && !bus.flush && (count < DEPTH_C);
  assign accept     = bus.alu_re && bus.rs_read_rdy && bus.execute_pkt.is_valid;
  assign push       = accept && core_wb_en && bus.execute_pkt.has_rd;
  assign pop        = !kill && bus.cdb_gnt && (count != '0);

  always_ff @(posedge clk) begin
    if (kill) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo_q[tail] <= '{is_valid: 1'b1,
                          dest_tag: bus.execute_pkt.dest_tag,
                          result:   core_result};
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Branch outputs are zeroed whenever no branch/jump resolved, not held
  always_ff @(posedge clk) begin
    if (kill || !(accept && core_br_en)) begin
      br_valid_q      <= 1'b0;
      br_taken_q      <= 1'b0;
      br_mispredict_q <= 1'b0;
      br_target_q     <= '0;
      br_pc_q         <= '0;
    end else begin
      br_valid_q      <= 1'b1;
      br_taken_q      <= core_taken;
      br_mispredict_q <= core_mispredict;
      br_target_q     <= core_target;
      br_pc_q         <= bus.execute_pkt.pc;
    end
  end

  assign bus.wb_pkt        = (count != '0) ? fifo_q[head] : '0;
  assign bus.br_valid      = br_valid_q;
  assign bus.br_taken_act  = br_taken_q;
  assign bus.br_mispredict = br_mispredict_q;
  assign bus.br_target     = br_target_q;
  assign bus.br_pc         = br_pc_q;

endmodule
